agp32_mem_ctrl: RTL and testbench
=================================

AGP32_MEM_CTRL -- requirements
Module: agp32_mem_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 16, number of post-reset cycles before the backing memory is declared usable.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles waited for mem_gnt or mem_rvalid before an access is declared failed.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge clk only.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 command  in  3  processor request: 0 none, 1 instruction fetch, 2 data read, 3 data write, 4 interrupt/no-op.
REQ-006 PC  in  32  instruction fetch address.
REQ-007 data_addr / data_wdata  in  32 each  data address; write data.
REQ-008 data_wstrb  in  4  byte-lane write strobe.
REQ-009 ready  out  1  high = controller idle, inst_rdata/data_rdata valid.
REQ-010 inst_rdata / data_rdata  out  32 each  last fetched instruction; last read data word.
REQ-011 mem_start_ready  out  1  high = init phase complete.
REQ-012 error  out  2  0 ok, 1 bus error, 2 misaligned PC, 3 timeout.
REQ-013 mem_req, mem_we  out  1 each  backing-memory request; write enable.
REQ-014 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-015 mem_wdata / mem_wstrb  out  32 / 4  write data; byte strobe.
REQ-016 mem_gnt, mem_rvalid, mem_err  in  1 each  request accepted; read data valid; access failed.
REQ-017 mem_rdata  in  32  read data, valid with mem_rvalid.

Function
REQ-018 FSM states SHALL be INIT, IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, ERR.
REQ-019 INIT: counter counts INIT_CYCLES cycles, then mem_start_ready rises (stays high until rst) and FSM enters IDLE with ready low.
REQ-020 IDLE with command 0: hold; ready held at its current value.
REQ-021 Command sampled only in IDLE; on nonzero command ready drops on the next edge and the command, PC, data_addr, data_wdata, data_wstrb are latched.
REQ-022 Command 1 -> I_REQ; commands 2/3 -> D_REQ, then I_REQ after data phase completes; command 4 -> ready rises one cycle later, no memory access, rdata outputs unchanged.
REQ-023 Commands 5-7 SHALL be treated as command 4.
REQ-024 Commands arriving while ready is low or FSM not in IDLE SHALL be ignored.
REQ-025 D_REQ/I_REQ: mem_req high with mem_addr = {addr[31:2],2'b00}; held stable until mem_gnt; mem_req drops the cycle after mem_gnt.
REQ-026 Data write: mem_we=1, mem_wdata/mem_wstrb = latched values; completes on mem_gnt (no rvalid expected).
REQ-027 Data read and fetch: mem_we=0, mem_wstrb=0; after mem_gnt wait in *_WAIT for mem_rvalid; capture mem_rdata into data_rdata or inst_rdata that cycle.
REQ-028 After fetch data captured, FSM returns to IDLE and ready rises on the following edge; ready-to-ready minimum latency for command 1 with gnt and rvalid both zero-wait = 3 cycles.
REQ-029 Latched PC[1:0] != 0 on entry to I_REQ: no request issued, error=2, go to ERR.
REQ-030 mem_err high in any REQ/WAIT state: error=1, ERR; takes priority over same-cycle mem_gnt/mem_rvalid.
REQ-031 Timeout counter (8 bits min, saturating) resets on entry to each REQ/WAIT state; reaching TIMEOUT -> error=3, ERR.
REQ-032 ERR: terminal until rst; ready low, mem_req low, error held; first error code wins.
REQ-033 mem_rvalid outside WAIT states SHALL be ignored.

Reset
REQ-034 rst SHALL, at any state including mid-access, force: FSM=INIT, ready=0, mem_start_ready=0, error=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, inst_rdata=32'd63 (NOP), data_rdata=0, counters=0.
REQ-035 An access in flight at rst SHALL be abandoned; later mem_gnt/mem_rvalid for it are ignored until a new request is issued.

Verification
REQ-036 Boot: rst 1 cycle, INIT_CYCLES=16 -> mem_start_ready rises exactly 16 cycles after rst release; command 1 PC=0x100, mem returns 0x12345678 -> inst_rdata=0x12345678, ready=1.
REQ-037 Read: command 2 data_addr=0x203, PC=0x104 -> mem_addr 0x200 then 0x104, data_rdata and inst_rdata updated, ready high only after both.
REQ-038 Byte write: command 3 data_addr=0x302, data_wstrb=4'b0100, data_wdata=0xAB0000 -> one write at 0x300 with strobe 0100, then fetch; no rvalid consumed for write.
REQ-039 Errors: PC=0x102 fetch -> error=2, mem_req never asserted; mem_err with mem_rvalid same cycle -> error=1; gnt withheld 255 cycles -> error=3.
REQ-040 Mid-access reset: rst while in D_WAIT, then stray mem_rvalid -> data_rdata stays 0, FSM restarts INIT.

Source files
------------

// File: rtl/agp32_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : agp32_mem_ctrl
//  Description : Processor-side memory controller. Waits out a boot phase,
//                then serves fetch / data read / data write commands against
//                a request/grant/rvalid backing memory, with alignment,
//                bus-error and timeout detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module agp32_mem_ctrl #(
  parameter int INIT_CYCLES = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        mem_start_ready,
  output logic [1:0]  error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int IW = ($clog2(INIT_CYCLES + 1) > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] I_LAST = IW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);

  localparam logic [2:0]  CMD_NONE  = 3'd0;
  localparam logic [2:0]  CMD_FETCH = 3'd1;
  localparam logic [2:0]  CMD_READ  = 3'd2;
  localparam logic [2:0]  CMD_WRITE = 3'd3;

  localparam logic [1:0]  ERR_BUS     = 2'd1;
  localparam logic [1:0]  ERR_ALIGN   = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] NOP_INSN = 32'd63;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    D_REQ  = 3'd2,
    D_WAIT = 3'd3,
    I_REQ  = 3'd4,
    I_WAIT = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [IW-1:0]   r_icnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_ready_pend;
  logic            r_is_write;
  logic [29:0]     r_pc_word;
  logic            r_pc_mis;
  logic [29:0]     r_daddr_word;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;

  logic            w_accept;
  logic            w_init_done;
  logic            w_timeout;
  logic            w_go_ready;
  logic            w_err_load;
  logic [1:0]      w_err_code;
  logic            w_cap_d;
  logic            w_cap_i;

  // Only word accesses are issued, so the data address byte offset is dropped.
  logic            unused_daddr_lsbs;
  assign unused_daddr_lsbs = ^data_addr[1:0];

  assign w_accept    = (state == IDLE) && ready && (command != CMD_NONE);
  assign w_init_done = (r_icnt >= I_LAST);
  assign w_timeout   = (r_tcnt >= T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Next-state decode, memory-side outputs and datapath strobes.
  always_comb begin
    next_state = state;
    w_err_load = 1'b0;
    w_err_code = 2'd0;
    w_cap_d    = 1'b0;
    w_cap_i    = 1'b0;
    w_go_ready = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wstrb  = 4'd0;
    mem_wdata  = r_wdata;
    case (state)
      INIT: begin
        if (w_init_done) begin
          next_state = IDLE;
          w_go_ready = 1'b1;
        end
      end
      IDLE: begin
        if (w_accept) begin
          if (command == CMD_FETCH) begin
            // A misaligned fetch never reaches the bus.
            if (PC[1:0] != 2'b00) begin
              next_state = ERR;
              w_err_load = 1'b1;
              w_err_code = ERR_ALIGN;
            end else begin
              next_state = I_REQ;
            end
          end else if ((command == CMD_READ) || (command == CMD_WRITE)) begin
            next_state = D_REQ;
          end else begin
            // Interrupt / no-op and unused encodings: handshake only.
            w_go_ready = 1'b1;
          end
        end
      end
      D_REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_is_write;
        mem_addr  = {r_daddr_word, 2'b00};
        mem_wstrb = r_is_write ? r_wstrb : 4'd0;
        if (mem_err) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_BUS;
        end else if (mem_gnt) begin
          if (!r_is_write) begin
            next_state = D_WAIT;
          end else if (r_pc_mis) begin
            next_state = ERR;
            w_err_load = 1'b1;
            w_err_code = ERR_ALIGN;
          end else begin
            next_state = I_REQ;
          end
        end else if (w_timeout) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      D_WAIT: begin
        if (mem_err) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_BUS;
        end else if (mem_rvalid) begin
          w_cap_d = 1'b1;
          if (r_pc_mis) begin
            next_state = ERR;
            w_err_load = 1'b1;
            w_err_code = ERR_ALIGN;
          end else begin
            next_state = I_REQ;
          end
        end else if (w_timeout) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      I_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_pc_word, 2'b00};
        if (mem_err) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_BUS;
        end else if (mem_gnt) begin
          next_state = I_WAIT;
        end else if (w_timeout) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      I_WAIT: begin
        if (mem_err) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_BUS;
        end else if (mem_rvalid) begin
          w_cap_i    = 1'b1;
          next_state = IDLE;
          w_go_ready = 1'b1;
        end else if (w_timeout) begin
          next_state = ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      ERR: begin
        next_state = ERR;
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  // Boot counter; mem_start_ready is sticky until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_icnt          <= '0;
      mem_start_ready <= 1'b0;
    end else if (state == INIT) begin
      if (w_init_done) mem_start_ready <= 1'b1;
      else             r_icnt          <= r_icnt + 1'b1;
    end
  end

  // Saturating per-state wait counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst)                      r_tcnt <= '0;
    else if (next_state != state) r_tcnt <= '0;
    else if (r_tcnt != '1)        r_tcnt <= r_tcnt + 1'b1;
  end

  // ready drops on an accepted command and rises one edge after completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready        <= 1'b0;
      r_ready_pend <= 1'b0;
    end else if (r_ready_pend) begin
      ready        <= 1'b1;
      r_ready_pend <= 1'b0;
    end else begin
      if (w_accept)   ready        <= 1'b0;
      if (w_go_ready) r_ready_pend <= 1'b1;
    end
  end

  // Command operand capture at acceptance time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write   <= 1'b0;
      r_pc_word    <= '0;
      r_pc_mis     <= 1'b0;
      r_daddr_word <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else if (w_accept) begin
      r_is_write   <= (command == CMD_WRITE);
      r_pc_word    <= PC[31:2];
      r_pc_mis     <= (PC[1:0] != 2'b00);
      r_daddr_word <= data_addr[31:2];
      r_wdata      <= data_wdata;
      r_wstrb      <= data_wstrb;
    end
  end

  // Error code: only the first failure is recorded, ERR is terminal.
  always_ff @(posedge clk) begin
    if (rst)             error <= 2'd0;
    else if (w_err_load) error <= w_err_code;
  end

  // Read data capture into the instruction / data result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata <= NOP_INSN;
      data_rdata <= 32'd0;
    end else begin
      if (w_cap_d) data_rdata <= mem_rdata;
      if (w_cap_i) inst_rdata <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_agp32_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_agp32_mem_ctrl
//  Description : Directed self-checking bench for agp32_mem_ctrl with a
//                scoreboard of expected memory transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agp32_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  command;
  logic [31:0] PC, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        ready;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_start_ready;
  logic [1:0]  error;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int c0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  agp32_mem_ctrl #(.INIT_CYCLES(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .command(command), .PC(PC),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .ready(ready), .inst_rdata(inst_rdata), .data_rdata(data_rdata),
    .mem_start_ready(mem_start_ready), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_err(mem_err),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_mem(input logic [31:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] d);
    exp_q.push_back('{addr: a, we: w, wstrb: s, wdata: d});
  endtask

  // Called at a falling edge; leaves the bench one falling edge later.
  task automatic issue(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] ws);
    chk("ready_before_cmd", 32'(ready), 32'd1);
    command = c; PC = pc; data_addr = da; data_wdata = wd; data_wstrb = ws;
    @(negedge clk);
    command = 3'd0;
  endtask

  // Serve one memory access: compare the request against the scoreboard,
  // grant after gnt_wait cycles, then return read data after rv_wait cycles.
  task automatic mem_serve(input string tag, input int gnt_wait, input int rv_wait,
                           input logic [31:0] rdata, input bit is_write, input bit inj_err);
    int t;
    mem_txn_t e;
    t = 0;
    while (mem_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    if (mem_req !== 1'b1) return;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_scoreboard: observed request at 0x%08h expected none", tag, mem_addr);
      return;
    end
    e = exp_q.pop_front();
    for (int w = 0; w <= gnt_wait; w++) begin
      chk({tag, "_addr"},  mem_addr, e.addr);
      chk({tag, "_we"},    32'(mem_we), 32'(e.we));
      chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
      if (e.we) chk({tag, "_wdata"}, mem_wdata, e.wdata);
      if (w < gnt_wait) @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    if (!is_write) begin
      chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      repeat (rv_wait) @(negedge clk);
      mem_rdata  = rdata;
      mem_rvalid = 1'b1;
      mem_err    = inj_err;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    command = 3'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; command = 3'd0; PC = 32'd0; data_addr = 32'd0; data_wdata = 32'd0;
    data_wstrb = 4'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_msr", 32'(mem_start_ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst", inst_rdata, 32'd63);
    chk("rst_data", data_rdata, 32'd0);

    // Boot: mem_start_ready on the 16th edge after release, ready one edge later
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("boot_msr_early", 32'(mem_start_ready), 32'd0);
    @(negedge clk);
    chk("boot_msr", 32'(mem_start_ready), 32'd1);
    chk("boot_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    chk("boot_ready", 32'(ready), 32'd1);

    // Zero-wait fetch, ready-to-ready latency
    expect_mem(32'h100, 1'b0, 4'd0, 32'd0);
    c0 = cyc;
    issue(3'd1, 32'h100, 32'd0, 32'd0, 4'd0);
    mem_serve("fetch", 0, 0, 32'h12345678, 1'b0, 1'b0);
    chk("fetch_ready_mid", 32'(ready), 32'd0);
    wait_ready("fetch");
    chk("fetch_latency", 32'(cyc - c0 - 1), 32'd3);
    chk("fetch_inst", inst_rdata, 32'h12345678);
    chk("fetch_data_kept", data_rdata, 32'd0);

    // No-op commands 4 and 6: one-cycle handshake, no bus traffic
    issue(3'd4, 32'h0, 32'd0, 32'd0, 4'd0);
    chk("nop4_ready_low", 32'(ready), 32'd0);
    chk("nop4_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("nop4_ready", 32'(ready), 32'd1);
    issue(3'd6, 32'h0, 32'd0, 32'd0, 4'd0);
    chk("nop6_ready_low", 32'(ready), 32'd0);
    chk("nop6_no_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("nop6_ready", 32'(ready), 32'd1);
    chk("nop_inst_kept", inst_rdata, 32'h12345678);

    // Data read then fetch; a command held while busy must be ignored
    expect_mem(32'h200, 1'b0, 4'd0, 32'd0);
    expect_mem(32'h104, 1'b0, 4'd0, 32'd0);
    issue(3'd2, 32'h104, 32'h203, 32'h99999999, 4'hF);
    command = 3'd3; data_addr = 32'h9990;
    mem_serve("rd_d", 2, 1, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("rd_ready_mid", 32'(ready), 32'd0);
    mem_serve("rd_i", 0, 0, 32'h00000013, 1'b0, 1'b0);
    wait_ready("rd");
    command = 3'd0;
    chk("rd_data", data_rdata, 32'hCAFEF00D);
    chk("rd_inst", inst_rdata, 32'h00000013);
    repeat (3) begin
      @(negedge clk);
      chk("rd_no_extra_req", 32'(mem_req), 32'd0);
    end
    chk("rd_sb_empty", 32'(exp_q.size()), 32'd0);

    // Byte write then fetch; stray rvalid after the write must be ignored
    expect_mem(32'h300, 1'b1, 4'b0100, 32'h00AB0000);
    expect_mem(32'h108, 1'b0, 4'd0, 32'd0);
    issue(3'd3, 32'h108, 32'h302, 32'h00AB0000, 4'b0100);
    mem_serve("wr_d", 1, 0, 32'd0, 1'b1, 1'b0);
    mem_rdata = 32'hDEADBEEF; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_serve("wr_i", 0, 0, 32'h00000055, 1'b0, 1'b0);
    wait_ready("wr");
    chk("wr_inst", inst_rdata, 32'h00000055);
    chk("wr_data_kept", data_rdata, 32'hCAFEF00D);

    // Misaligned fetch: no request, error 2
    issue(3'd1, 32'h102, 32'd0, 32'd0, 4'd0);
    repeat (5) begin
      chk("mis_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    chk("mis_error", 32'(error), 32'd2);
    chk("mis_ready", 32'(ready), 32'd0);

    // Bus error together with rvalid: error 1, data not captured
    do_reset();
    chk("rst2_error", 32'(error), 32'd0);
    chk("rst2_msr", 32'(mem_start_ready), 32'd0);
    wait_ready("boot2");
    expect_mem(32'h400, 1'b0, 4'd0, 32'd0);
    issue(3'd2, 32'h0, 32'h400, 32'd0, 4'd0);
    mem_serve("berr", 0, 0, 32'h11111111, 1'b0, 1'b1);
    chk("berr_error", 32'(error), 32'd1);
    chk("berr_data", data_rdata, 32'd0);
    chk("berr_ready", 32'(ready), 32'd0);
    chk("berr_no_req", 32'(mem_req), 32'd0);

    // Grant withheld: timeout after 255 cycles, first error code kept
    do_reset();
    wait_ready("boot3");
    issue(3'd1, 32'h500, 32'd0, 32'd0, 4'd0);
    repeat (250) @(negedge clk);
    chk("to_error_early", 32'(error), 32'd0);
    chk("to_req_held", 32'(mem_req), 32'd1);
    chk("to_addr_held", mem_addr, 32'h500);
    for (int t = 0; t < 20 && error === 2'd0; t++) @(negedge clk);
    chk("to_error", 32'(error), 32'd3);
    chk("to_no_req", 32'(mem_req), 32'd0);
    mem_err = 1'b1;
    @(negedge clk);
    mem_err = 1'b0;
    @(negedge clk);
    chk("to_first_wins", 32'(error), 32'd3);

    // Reset in D_WAIT, then stray rvalid/gnt for the abandoned access
    do_reset();
    wait_ready("boot4");
    issue(3'd2, 32'h0, 32'h600, 32'd0, 4'd0);
    chk("mr_addr", mem_addr, 32'h600);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rdata = 32'h77777777; mem_rvalid = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("mr_data", data_rdata, 32'd0);
    chk("mr_inst", inst_rdata, 32'd63);
    chk("mr_msr", 32'(mem_start_ready), 32'd0);
    chk("mr_ready", 32'(ready), 32'd0);
    chk("mr_no_req", 32'(mem_req), 32'd0);
    wait_ready("boot5");
    chk("mr_msr_after", 32'(mem_start_ready), 32'd1);
    chk("mr_data_after", data_rdata, 32'd0);
    chk("mr_error_after", 32'(error), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
